// File: rtl/main_fsm.sv
// main_fsm: multicycle RISC-V control FSM producing datapath strobes and mux selects.
// Define MAIN_FSM_JALR_EN to add the JALR / JALR_LINK states for op 1100111.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       Illegal
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] ALUWB    = 4'd7;
    localparam logic [3:0] EXECI    = 4'd8;
    localparam logic [3:0] JAL      = 4'd9;
    localparam logic [3:0] BEQ      = 4'd10;
    localparam logic [3:0] ILLEGAL  = 4'd11;
`ifdef MAIN_FSM_JALR_EN
    localparam logic [3:0] JALR      = 4'd12;
    localparam logic [3:0] JALR_LINK = 4'd13;
`endif

    logic [3:0] state, nxt, cur;

    always_ff @(posedge clk)
        state <= !reset ? FETCH : nxt;

    // While reset is low the outputs decode as FETCH, so mux selects take their FETCH values.
    assign cur = reset ? state : FETCH;

    assign ImmSrc = op == 7'b0100011 ? 2'b01 :
                    op == 7'b1100011 ? 2'b10 :
                    op == 7'b1101111 ? 2'b11 : 2'b00;

    always_comb begin
        nxt = state;
        case (state)
            FETCH:    nxt = MemReady ? DECODE : FETCH;
            DECODE:
                case (op)
                    7'b0000011, 7'b0100011: nxt = MEMADR;
                    7'b0110011:             nxt = EXECR;
                    7'b0010011:             nxt = EXECI;
                    7'b1101111:             nxt = JAL;
                    7'b1100011:             nxt = BEQ;
`ifdef MAIN_FSM_JALR_EN
                    7'b1100111:             nxt = JALR;
`endif
                    default:                nxt = ILLEGAL;
                endcase
            MEMADR:   nxt = op == 7'b0000011 ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt = MemReady ? MEMWB : MEMREAD;
            MEMWRITE: nxt = MemReady ? FETCH : MEMWRITE;
            MEMWB, ALUWB, BEQ: nxt = FETCH;
            EXECR, EXECI, JAL: nxt = ALUWB;
`ifdef MAIN_FSM_JALR_EN
            JALR:      nxt = JALR_LINK;
            JALR_LINK: nxt = ALUWB;
`endif
            ILLEGAL:  nxt = ILLEGAL;
            default:  nxt = FETCH;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        RegWrite  = 1'b0;
        Illegal   = 1'b0;
        case (cur)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady & reset;
                PCWrite   = MemReady & reset;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            ALUWB: RegWrite = 1'b1;
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = Zero;
            end
`ifdef MAIN_FSM_JALR_EN
            JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            JALR_LINK: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
`endif
            ILLEGAL: Illegal = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: expands each instruction into its expected per-cycle control vectors and
// compares them against main_fsm, with directed cases followed by a random instruction stream.
module tb_main_fsm;
    logic       clk = 1'b0;
    logic       reset, Zero, MemReady;
    logic [6:0] op;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [15:0] got;
    int n_tests = 0;
    int n_fail = 0;

    main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUOp, ImmSrc, RegWrite, Illegal};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: op=%b got %h expected %h", tag, op, obs, exp);
        end
    endtask

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        return o == 7'b0100011 ? 2'b01 : o == 7'b1100011 ? 2'b10 :
               o == 7'b1101111 ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [15:0] v(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] aop,
                                      input logic rw, input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, aop, imm_of(op), rw, ill};
    endfunction

    task automatic step(input string tag, input logic mr, input logic [15:0] exp);
        MemReady = mr;
        @(negedge clk);
        check(tag, got, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step("reset", 1'($urandom), v(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0));
        reset = 1'b1;
    endtask

    task automatic fetch_decode(input int fw);
        for (int i = 0; i < fw; i++)
            step("fetch_wait", 1'b0, v(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0));
        step("fetch", 1'b1, v(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0));
        step("decode", 1'($urandom), v(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0));
    endtask

    task automatic run(input logic [6:0] o, input logic z, input int fw, input int mw);
        op = o;
        Zero = z;
        fetch_decode(fw);
        case (o)
            7'b0000011: begin
                step("memadr", 1'($urandom), v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0));
                for (int i = 0; i < mw; i++)
                    step("memread_wait", 1'b0, v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
                step("memread", 1'b1, v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
                step("memwb", 1'($urandom), v(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0));
            end
            7'b0100011: begin
                step("memadr", 1'($urandom), v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0));
                for (int i = 0; i < mw; i++)
                    step("memwrite_wait", 1'b0, v(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
                step("memwrite", 1'b1, v(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
            end
            7'b0110011: begin
                step("execr", 1'($urandom), v(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0));
                step("aluwb", 1'($urandom), v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
            end
            7'b0010011: begin
                step("execi", 1'($urandom), v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0));
                step("aluwb", 1'($urandom), v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
            end
            7'b1101111: begin
                step("jal", 1'($urandom), v(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0));
                step("aluwb", 1'($urandom), v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
            end
            7'b1100011:
                step("beq", 1'($urandom), v(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0));
`ifdef MAIN_FSM_JALR_EN
            7'b1100111: begin
                step("jalr", 1'($urandom), v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0));
                step("jalr_link", 1'($urandom), v(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0));
                step("aluwb", 1'($urandom), v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
            end
`endif
            default: begin
                for (int i = 0; i < 3; i++) begin
                    Zero = 1'($urandom);
                    step("illegal", 1'($urandom), v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
                end
                pulse_reset();
            end
        endcase
    endtask

    initial begin
        logic [6:0] ops [9];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                7'b1100011, 7'b1100111, 7'b0000000, 7'b1111111};
        reset = 1'b0;
        op = 7'b0;
        Zero = 1'b0;
        MemReady = 1'b0;
        #1;
        step("reset_init", 1'b1, v(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0));
        step("reset_init2", 1'b0, v(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0));
        reset = 1'b1;
        run(7'b0110011, 1'b0, 0, 0);
        run(7'b0000011, 1'b0, 1, 3);
        run(7'b1100011, 1'b1, 0, 0);
        run(7'b1100011, 1'b0, 2, 0);
        run(7'b0100011, 1'b0, 0, 2);
        run(7'b1100111, 1'b0, 0, 0);
        run(7'b0010011, 1'b1, 0, 0);
        // reset pulses landing inside memory waits and a fetch wait
        op = 7'b0100011;
        fetch_decode(0);
        step("memadr", 1'b0, v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0));
        step("memwrite_wait", 1'b0, v(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
        pulse_reset();
        op = 7'b0000011;
        fetch_decode(1);
        step("memadr", 1'b0, v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0));
        step("memread_wait", 1'b0, v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
        pulse_reset();
        step("fetch_wait", 1'b0, v(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0));
        pulse_reset();
        for (int n = 0; n < 300; n++) begin
            int k;
            logic [6:0] o;
            k = $urandom_range(0, 9);
            o = k == 9 ? 7'($urandom) : ops[k];
            run(o, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 4));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
